// File: rtl/mem_arbiter.sv
// Line-granular memory arbiter: serialises dcache write-backs, dcache fills and icache fills
// onto one fixed-latency backing store, one request in service at a time.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned LINE_SIZE   = 128,
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned MEM_LINES   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_mem_req,
    input  logic [WORD_SIZE-1:0] ic_mem_req_addr,
    input  logic                 dc_mem_req,
    input  logic [WORD_SIZE-1:0] dc_mem_req_addr,
    input  logic                 dc_mem_write,
    input  logic [WORD_SIZE-1:0] dc_mem_write_addr,
    input  logic [LINE_SIZE-1:0] dc_mem_write_data,
    output logic                 ic_mem_res,
    output logic                 dc_mem_res,
    output logic [WORD_SIZE-1:0] mem_res_addr,
    output logic [LINE_SIZE-1:0] mem_res_data,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned OffW = $clog2(LINE_SIZE / 8);
    localparam int unsigned IdxW = $clog2(MEM_LINES);
    localparam int unsigned TagW = WORD_SIZE - OffW;
    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic StIdle  = 1'b0;
    localparam logic StServe = 1'b1;

    logic                 state_q;
    logic [CntW-1:0]      cnt_q;

    // Slots keep only the line-aligned part of the address.
    logic                 dw_v_q, dr_v_q, ir_v_q;
    logic [TagW-1:0]      dw_addr_q, dr_addr_q, ir_addr_q;
    logic [LINE_SIZE-1:0] dw_data_q;

    logic                 svc_wr_q, svc_ic_q;
    logic [TagW-1:0]      svc_addr_q;
    logic [LINE_SIZE-1:0] svc_data_q;

    logic                 ic_res_q, dc_res_q, ovf_q;
    logic [TagW-1:0]      res_addr_q;
    logic [LINE_SIZE-1:0] res_data_q;

    logic [LINE_SIZE-1:0] store [MEM_LINES];

    logic            grant, g_dw, g_dr, g_ir, done;
    logic [IdxW-1:0] svc_idx;

    assign grant   = (state_q == StIdle) && (dw_v_q || dr_v_q || ir_v_q);
    assign g_dw    = grant && dw_v_q;
    assign g_dr    = grant && !dw_v_q && dr_v_q;
    assign g_ir    = grant && !dw_v_q && !dr_v_q && ir_v_q;
    assign done    = (state_q == StServe) && (cnt_q == '0);
    assign svc_idx = svc_addr_q[IdxW-1:0];

    // Byte-offset bits are intentionally dropped.
    logic unused_offs;
    assign unused_offs = ^{ic_mem_req_addr[OffW-1:0], dc_mem_req_addr[OffW-1:0],
                           dc_mem_write_addr[OffW-1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dw_v_q     <= 1'b0;
            dr_v_q     <= 1'b0;
            ir_v_q     <= 1'b0;
            dw_addr_q  <= '0;
            dr_addr_q  <= '0;
            ir_addr_q  <= '0;
            dw_data_q  <= '0;
            svc_wr_q   <= 1'b0;
            svc_ic_q   <= 1'b0;
            svc_addr_q <= '0;
            svc_data_q <= '0;
            ic_res_q   <= 1'b0;
            dc_res_q   <= 1'b0;
            ovf_q      <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            ic_res_q <= 1'b0;
            dc_res_q <= 1'b0;

            // A slot being granted this edge is free to take a new request.
            if (dc_mem_write) begin
                if (dw_v_q && !g_dw) begin
                    ovf_q <= 1'b1;
                end else begin
                    dw_v_q    <= 1'b1;
                    dw_addr_q <= dc_mem_write_addr[WORD_SIZE-1:OffW];
                    dw_data_q <= dc_mem_write_data;
                end
            end else if (g_dw) begin
                dw_v_q <= 1'b0;
            end

            if (dc_mem_req) begin
                if (dr_v_q && !g_dr) begin
                    ovf_q <= 1'b1;
                end else begin
                    dr_v_q    <= 1'b1;
                    dr_addr_q <= dc_mem_req_addr[WORD_SIZE-1:OffW];
                end
            end else if (g_dr) begin
                dr_v_q <= 1'b0;
            end

            if (ic_mem_req) begin
                if (ir_v_q && !g_ir) begin
                    ovf_q <= 1'b1;
                end else begin
                    ir_v_q    <= 1'b1;
                    ir_addr_q <= ic_mem_req_addr[WORD_SIZE-1:OffW];
                end
            end else if (g_ir) begin
                ir_v_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q    <= StServe;
                        cnt_q      <= CntW'(MEM_LATENCY - 1);
                        svc_wr_q   <= g_dw;
                        svc_ic_q   <= g_ir;
                        svc_addr_q <= g_dw ? dw_addr_q : (g_dr ? dr_addr_q : ir_addr_q);
                        svc_data_q <= dw_data_q;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        if (!svc_wr_q) begin
                            ic_res_q   <= svc_ic_q;
                            dc_res_q   <= !svc_ic_q;
                            res_addr_q <= svc_addr_q;
                            res_data_q <= store[svc_idx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Backing store survives reset; a write cut short by reset never lands.
    always_ff @(posedge clk) begin
        if (rst && done && svc_wr_q) begin
            store[svc_idx] <= svc_data_q;
        end
    end

    assign busy         = (state_q == StServe);
    assign ic_mem_res   = ic_res_q;
    assign dc_mem_res   = dc_res_q;
    assign overflow     = ovf_q;
    assign mem_res_addr = {res_addr_q, {OffW{1'b0}}};
    assign mem_res_data = res_data_q;

endmodule
